slot_writer16_28bit: RTL



---
 rtl/slot_writer16_28bit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/slot_writer16_28bit.sv
// slot_writer16_28bit: sixteen-slot, 28-bit register bank feeding a 16:1 select path.
// One write per cycle over WR_VALID/WR_READY; a flush engine clears one slot per cycle.
// Optional per-slot even parity is compiled in with SLOT_WRITER_PARITY_EN.
//
// Handshake: a write is accepted on a rising CLK edge where WR_VALID && WR_READY.
// WR_READY is combinational and low while flushing or while FLUSH is requested.
// The requester holds WR_VALID/WR_SELECT/WR_DATA stable until it sees acceptance.
// WR_ACK pulses for one cycle after each accepted write, and back-to-back writes
// hold it high continuously.
module slot_writer16_28bit (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         WR_VALID,
    output logic         WR_READY,
    input  logic [3:0]   WR_SELECT,
    input  logic [27:0]  WR_DATA,
    output logic         WR_ACK,
    input  logic         FLUSH,
    output logic         BUSY,
    output logic [447:0] SLOT_DATA,
    output logic [15:0]  SLOT_VALID,
    output logic [0:0]   DBG_STATE
`ifdef SLOT_WRITER_PARITY_EN
    ,
    output logic [15:0]  SLOT_PARITY
`endif
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  fcnt_q;
    logic [3:0]  fcnt_d;
    logic        busy_d;
    logic        wr_fire;

    logic [27:0] slot_q [16];
    logic [15:0] valid_q;

`ifdef SLOT_WRITER_PARITY_EN
    logic [15:0] parity_q;
`else
    // Parity storage is not built in this configuration.
`endif

    // A write needs an idle bank and no flush request in the same cycle.
    assign WR_READY  = (state_q == ST_IDLE) && !FLUSH;
    assign wr_fire   = WR_VALID && WR_READY;
    assign DBG_STATE = state_q;

    // State, flush counter and BUSY register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            fcnt_q  <= 4'd0;
            BUSY    <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            BUSY    <= busy_d;
        end
    end

    // Next-state logic: enter flush on request, walk slots 0..15, return to idle.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        busy_d  = BUSY;
        case (state_q)
            ST_IDLE: begin
                if (FLUSH) begin
                    state_d = ST_FLUSH;
                    fcnt_d  = 4'd0;
                    busy_d  = 1'b1;
                end
            end
            ST_FLUSH: begin
                // FLUSH is ignored here: no restart, no queuing.
                fcnt_d = fcnt_q + 4'd1;
                if (fcnt_q == 4'd15) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                fcnt_d  = 4'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Slot storage: reset clears everything, flush clears slot FCNT, else accept a write.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 16; i++) begin
                slot_q[i] <= 28'd0;
            end
            valid_q <= 16'h0000;
        end else if (state_q == ST_FLUSH) begin
            slot_q[fcnt_q]  <= 28'd0;
            valid_q[fcnt_q] <= 1'b0;
        end else if (wr_fire) begin
            slot_q[WR_SELECT]  <= WR_DATA;
            valid_q[WR_SELECT] <= 1'b1;
        end
    end

`ifdef SLOT_WRITER_PARITY_EN
    // Even-parity bit per slot, tracking the same clear/write rules as the data.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            parity_q <= 16'h0000;
        end else if (state_q == ST_FLUSH) begin
            parity_q[fcnt_q] <= 1'b0;
        end else if (wr_fire) begin
            parity_q[WR_SELECT] <= ^WR_DATA;
        end
    end

    assign SLOT_PARITY = parity_q;
`endif

    // Write acknowledge: one cycle after each accepted write.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            WR_ACK <= 1'b0;
        end else begin
            WR_ACK <= wr_fire;
        end
    end

    // Flatten the slot array onto the parallel read bus.
    always_comb begin
        SLOT_DATA = '0;
        for (int i = 0; i < 16; i++) begin
            SLOT_DATA[28*i +: 28] = slot_q[i];
        end
    end

    assign SLOT_VALID = valid_q;

endmodule
